// File: rtl/bp_nonsynth_io_cmd_arbiter.sv
// bp_nonsynth_io_cmd_arbiter: round-robin sharing of one credit-limited I/O command link among nonsynth requesters
// Ports: req_cmd_*    per-requester command slices, valids and yumis
//        io_cmd_*     arbitrated command toward the link
//        io_resp_*    in-order responses from the link
//        req_resp_*   response broadcast with one-hot valid to the issuing requester
//        credit_count_o, err_o, idle_o  outstanding count, sticky unexpected-response flag, idle
// Optional: define BP_NONSYNTH_IO_ARB_BURST_LOCK_EN to hold the grant on one requester for up to burst_max_p accepts.
module bp_nonsynth_io_cmd_arbiter #(
  parameter int num_req_p     = 2,
  parameter int msg_width_p   = 128,
  parameter int max_credits_p = 8,
  parameter int burst_max_p   = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p*msg_width_p-1:0]   req_cmd_i,
  input  logic [num_req_p-1:0]               req_cmd_v_i,
  output logic [num_req_p-1:0]               req_cmd_yumi_o,
  output logic [msg_width_p-1:0]             io_cmd_o,
  output logic                               io_cmd_v_o,
  input  logic                               io_cmd_yumi_i,
  input  logic [msg_width_p-1:0]             io_resp_i,
  input  logic                               io_resp_v_i,
  output logic                               io_resp_ready_o,
  output logic [msg_width_p-1:0]             req_resp_o,
  output logic [num_req_p-1:0]               req_resp_v_o,
  input  logic [num_req_p-1:0]               req_resp_ready_i,
  output logic [$clog2(max_credits_p+1)-1:0] credit_count_o,
  output logic                               err_o,
  output logic                               idle_o
);
  localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_w_lp = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;
  localparam int cnt_w_lp = $clog2(max_credits_p + 1);
  logic [idx_w_lp-1:0] p_q, p_d, g, h;
  logic [idx_w_lp-1:0] tag_q [max_credits_p];
  logic [ptr_w_lp-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic err_q, err_d, rdy_q, en, empty, push, pop;
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] x);
    return (x == ptr_w_lp'(max_credits_p - 1)) ? '0 : x + 1'b1;
  endfunction
  function automatic logic [idx_w_lp-1:0] idx_inc(input logic [idx_w_lp-1:0] x);
    return (x == idx_w_lp'(num_req_p - 1)) ? '0 : x + 1'b1;
  endfunction
  // rdy_q holds everything quiet during reset and for the first cycle after it
  assign en    = rdy_q & ~reset_i;
  assign empty = (cnt_q == '0);
  assign h     = tag_q[rd_q];
  always_comb begin
    g = p_q;
    for (int k = num_req_p - 1; k >= 0; k--)
      if (req_cmd_v_i[(int'(p_q) + k) % num_req_p]) g = idx_w_lp'((int'(p_q) + k) % num_req_p);
  end
  assign io_cmd_o        = req_cmd_i[g*msg_width_p +: msg_width_p];
  assign io_cmd_v_o      = en & (|req_cmd_v_i) & (cnt_q != cnt_w_lp'(max_credits_p));
  assign push            = io_cmd_v_o & io_cmd_yumi_i;
  assign req_cmd_yumi_o  = push ? (num_req_p'(1) << g) : '0;
  // With nothing outstanding the response is swallowed so the link never stalls
  assign io_resp_ready_o = en & (empty | req_resp_ready_i[h]);
  assign pop             = io_resp_v_i & io_resp_ready_o & ~empty;
  assign req_resp_v_o    = (en & ~empty & io_resp_v_i) ? (num_req_p'(1) << h) : '0;
  assign req_resp_o      = io_resp_i;
  assign credit_count_o  = cnt_q;
  assign err_o           = err_q;
  assign idle_o          = empty & ~|req_cmd_v_i;
  always_comb begin
    wr_d  = push ? ptr_inc(wr_q) : wr_q;
    rd_d  = pop ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    err_d = err_q | (en & io_resp_v_i & empty);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      p_q   <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      rdy_q <= 1'b1;
    end
  end
  always_ff @(posedge clk_i)
    if (push) tag_q[wr_q] <= g;
`ifdef BP_NONSYNTH_IO_ARB_BURST_LOCK_EN
  localparam int bw_lp = $clog2(burst_max_p + 1);
  logic [bw_lp-1:0] bc_q, bc_d, bc_n;
  logic lock_q, lock_d, rel;
  // A grant to someone other than the locked requester starts a fresh burst
  always_comb begin
    bc_n   = (lock_q & (g == p_q)) ? bc_q + 1'b1 : bw_lp'(1);
    rel    = (bc_n >= bw_lp'(burst_max_p));
    p_d    = push ? (rel ? idx_inc(g) : g) : ((lock_q & ~req_cmd_v_i[p_q]) ? idx_inc(p_q) : p_q);
    lock_d = push ? ~rel : (lock_q & req_cmd_v_i[p_q]);
    bc_d   = lock_d ? (push ? bc_n : bc_q) : '0;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bc_q   <= '0;
      lock_q <= 1'b0;
    end else begin
      bc_q   <= bc_d;
      lock_q <= lock_d;
    end
  end
`else
  assign p_d = push ? idx_inc(g) : p_q;
`endif
endmodule

// File: doc/bp_nonsynth_io_cmd_arbiter.md
Name: bp_nonsynth_io_cmd_arbiter

Overview:
- Shares a single credit-limited I/O command link between num_req_p nonsynth requesters, for example the NBF loader and a host/debug bridge.
- Arbitrates commands round-robin and tracks outstanding credits.
- Records the requester index of every sent command, so in-order I/O responses return to the requester that issued them.
- Sits between the requesters and the I/O network port of the processor under test.

Parameters:
- num_req_p, 2: number of requesters (at least 1).
- msg_width_p, 128: width of one command or response message.
- max_credits_p, 8: maximum outstanding commands; also the depth of the tag FIFO.
- burst_max_p, 4: maximum consecutive grants while locked. Used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; synchronous, active-high.
- req_cmd_i  in  num_req_p*msg_width_p  commands, one slice per requester; slice i is bits [i*msg_width_p +: msg_width_p].
- req_cmd_v_i  in  num_req_p  per-requester command valid.
- req_cmd_yumi_o  out  num_req_p  per-requester command accepted.
- io_cmd_o  out  msg_width_p  selected command.
- io_cmd_v_o  out  1  command valid to the link.
- io_cmd_yumi_i  in  1  link consumes the command.
- io_resp_i  in  msg_width_p  response from the link.
- io_resp_v_i  in  1  response valid.
- io_resp_ready_o  out  1  arbiter can accept the response.
- req_resp_o  out  msg_width_p  response, broadcast to all requesters.
- req_resp_v_o  out  num_req_p  one-hot response valid.
- req_resp_ready_i  in  num_req_p  per-requester response ready.
- credit_count_o  out  clog2(max_credits_p+1)  outstanding commands.
- err_o  out  1  sticky error: a response arrived with nothing outstanding.
- idle_o  out  1  no outstanding commands and no requester valid.

Behaviour:
- Reset:
  - Clears credit count, tag FIFO, round-robin pointer (requester 0 has highest priority), err_o and lock state.
  - During reset and on the first cycle after it: io_cmd_v_o=0, req_cmd_yumi_o=0, req_resp_v_o=0, credit_count_o=0, err_o=0.
  - A reset mid-operation discards all outstanding tags. Responses arriving after reset are treated as unexpected.
- Grant:
  - Combinational. Select the first valid requester, scanning from pointer p upward with wrap-around.
  - io_cmd_o carries the selected slice. When no requester is valid, io_cmd_o is don't-care.
- Command valid: io_cmd_v_o = any req_cmd_v_i & (credit_count_o != max_credits_p).
  - Does not depend on io_cmd_yumi_i.
  - credit_count_o == max_credits_p also means the tag FIFO is full.
- Command accept: req_cmd_yumi_o[g] = io_cmd_yumi_i for the granted index g; all other bits are 0.
- On an accepted command (io_cmd_yumi_i):
  - Push g into the tag FIFO.
  - Set p <= (g+1) mod num_req_p.
  - Increment credit_count.
- Response path:
  - Let h be the FIFO head. When the FIFO is non-empty: io_resp_ready_o = req_resp_ready_i[h]; req_resp_v_o = onehot(h) & io_resp_v_i; req_resp_o = io_resp_i.
  - A response is accepted when io_resp_v_i & io_resp_ready_o. Acceptance pops the FIFO and decrements credit_count.
- Empty-FIFO response:
  - io_resp_ready_o=1; the response is dropped and req_resp_v_o=0.
  - err_o is set next cycle and holds until reset.
  - credit_count stays 0; no underflow.
- Simultaneous command accept and response accept in one cycle: count unchanged; FIFO pushes and pops.
- FIFO/counter boundaries:
  - Count is registered, so a response that frees the last credit enables io_cmd_v_o on the following cycle.
  - A push in the same cycle the FIFO goes empty is legal.
- idle_o = (credit_count_o==0) & ~|req_cmd_v_i.

Optional Feature:
- Macro: BP_NONSYNTH_IO_ARB_BURST_LOCK_EN.
- Defined:
  - After a grant to g is accepted, p stays at g while req_cmd_v_i[g] remains high, up to burst_max_p consecutive accepted grants.
  - The lock releases on the burst_max_p-th accept or when req_cmd_v_i[g] drops. On release, p = (g+1) mod num_req_p.
  - A burst counter of clog2(burst_max_p+1) bits is added, cleared by reset.
- Undefined: pure round-robin as above; burst_max_p is ignored.

Test Plan:
1. Configuration num_req_p=2, max_credits_p=4. Only requester 0 valid, yumi on every valid, no responses -> four accepts, credit_count_o=4, then io_cmd_v_o=0. One response -> credit_count_o=3 and io_cmd_v_o=1 the next cycle.
2. Both requesters valid continuously, yumi every cycle, responses returned every cycle -> grant order 0,1,0,1,0,1.
3. Send from requesters 0,1,1, then return three responses -> req_resp_v_o = 2'b01, 2'b10, 2'b10; credit_count_o back to 0.
4. At credit_count_o=2, a command accept and a response accept in the same cycle -> credit_count_o stays 2. Head requester with req_resp_ready_i=0 -> io_resp_ready_o=0 until ready rises.
5. io_resp_v_i=1 with credit_count_o=0 -> io_resp_ready_o=1, req_resp_v_o=0, err_o=1 next cycle, held. reset_i pulse -> err_o=0.
6. With the macro defined and burst_max_p=4, both requesters valid -> grants 0,0,0,0,1,1,1,1. With the macro undefined -> grants 0,1,0,1.
